fetch_instr_queue: RTL and testbench

- Decoupling buffer between the 64-bit fetch stage and the dual-issue stage.
- Accepts aligned two-instruction fetch packets (or a single upper instruction after a redirect to pc[2]=1).
- Stores instructions individually in program order.
- Presents the two oldest as slot 0 and slot 1 to the issue stage; issue consumes 0, 1 or 2 per cycle. Flush on branch redirect empties the queue.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_queue_storage.sv | 42 ++++
 rtl/fetch_instr_queue.sv | 110 +++++++++++
 tb/tb_fetch_instr_queue.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the fetch instruction queue: one queued entry is an
// instruction word together with the PC it was fetched from.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fq_entry_t;

  // Issue retires in order: slot 1 may only go together with slot 0.
  function automatic logic [1:0] issue_request(input logic issue0, input logic issue1);
    if (issue0 && issue1) return 2'd2;
    if (issue0)           return 2'd1;
    return 2'd0;
  endfunction

endpackage

// File: rtl/fetch_queue_storage.sv
// DEPTH-entry register file for the fetch queue: two write ports at
// tail/tail+1 and two combinational read ports at head/head+1.
module fetch_queue_storage
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we0,
  input  logic [PTR_W-1:0] waddr0,
  input  fq_entry_t        wdata0,
  input  logic             we1,
  input  logic [PTR_W-1:0] waddr1,
  input  fq_entry_t        wdata1,
  input  logic [PTR_W-1:0] raddr0,
  input  logic [PTR_W-1:0] raddr1,
  output fq_entry_t        rdata0,
  output fq_entry_t        rdata1
);

  fq_entry_t mem [DEPTH];

  // NOTE: the storage itself is reset so that the slot data outputs read as
  // zero during reset; this costs a reset net per flop but is required here.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // The two write addresses are always tail and tail+1, so never collide.
      if (we0) mem[waddr0] <= wdata0;
      if (we1) mem[waddr1] <= wdata1;
    end
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/fetch_instr_queue.sv
// Decoupling queue between the 64-bit fetch stage and the dual-issue stage;
// stores single instructions in program order and presents the two oldest.
module fetch_instr_queue
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        fetch_valid_i,
  output logic        fetch_accept_o,
  input  logic [31:0] fetch_pc_i,
  input  logic [63:0] fetch_instr_i,
  output logic        fetch0_valid_o,
  output logic [31:0] fetch0_instr_o,
  output logic [31:0] fetch0_pc_o,
  output logic        fetch1_valid_o,
  output logic [31:0] fetch1_instr_o,
  output logic [31:0] fetch1_pc_o,
  input  logic        issue0_accept_i,
  input  logic        issue1_accept_i
);

  localparam logic [PTR_W:0] ACCEPT_MAX = (PTR_W + 1)'(DEPTH - 2);
  localparam logic [PTR_W:0] ONE        = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0] TWO        = (PTR_W + 1)'(2);

  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W:0]   count_q;

  logic             wr_en;
  logic             wr_single;
  logic [PTR_W:0]   wr_cnt;
  logic [PTR_W:0]   rd_req;
  logic [PTR_W:0]   rd_cnt;
  logic [31:0]      pc_lo, pc_hi;
  fq_entry_t        wdata0, wdata1;
  fq_entry_t        rdata0, rdata1;

  // Accept depends only on registered occupancy, never on this cycle's issue.
  assign fetch_accept_o = (count_q <= ACCEPT_MAX);

  assign wr_en     = fetch_valid_i && fetch_accept_o && !flush_i;
  assign wr_single = fetch_pc_i[2];
  assign pc_lo     = {fetch_pc_i[31:3], 3'b000};
  assign pc_hi     = {fetch_pc_i[31:3], 3'b100};

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    wr_cnt = '0;
    wdata0 = '{instr: fetch_instr_i[31:0],  pc: pc_lo};
    wdata1 = '{instr: fetch_instr_i[63:32], pc: pc_hi};
    if (wr_en) begin
      if (wr_single) begin
        wr_cnt = ONE;
        wdata0 = '{instr: fetch_instr_i[63:32], pc: pc_hi};
      end else begin
        wr_cnt = TWO;
      end
    end
  end

  // Reads beyond the valid entries are clamped away.
  assign rd_req = (PTR_W + 1)'(issue_request(issue0_accept_i, issue1_accept_i));
  assign rd_cnt = (count_q < rd_req) ? count_q : rd_req;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + rd_cnt[PTR_W-1:0];
      tail_q  <= tail_q + wr_cnt[PTR_W-1:0];
      count_q <= count_q + wr_cnt - rd_cnt;
    end
  end

  fetch_queue_storage #(.DEPTH(DEPTH)) u_storage (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we0    (wr_en),
    .waddr0 (tail_q),
    .wdata0 (wdata0),
    .we1    (wr_en && !wr_single),
    .waddr1 (tail_q + PTR_W'(1)),
    .wdata1 (wdata1),
    .raddr0 (head_q),
    .raddr1 (head_q + PTR_W'(1)),
    .rdata0 (rdata0),
    .rdata1 (rdata1)
  );

  assign fetch0_valid_o = (count_q >= ONE);
  assign fetch1_valid_o = (count_q >= TWO);
  assign fetch0_instr_o = rdata0.instr;
  assign fetch0_pc_o    = rdata0.pc;
  assign fetch1_instr_o = rdata1.instr;
  assign fetch1_pc_o    = rdata1.pc;

endmodule

// File: tb/tb_fetch_instr_queue.sv
// Self-checking bench for fetch_instr_queue: directed scenarios with literal
// expectations plus randomized traffic compared against a queue model.
module tb_fetch_instr_queue;

  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } model_entry_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        fetch_valid_i = 1'b0;
  logic        fetch_accept_o;
  logic [31:0] fetch_pc_i = '0;
  logic [63:0] fetch_instr_i = '0;
  logic        fetch0_valid_o, fetch1_valid_o;
  logic [31:0] fetch0_instr_o, fetch0_pc_o, fetch1_instr_o, fetch1_pc_o;
  logic        issue0_accept_i = 1'b0;
  logic        issue1_accept_i = 1'b0;

  model_entry_t mq[$];
  bit           cmp_en = 1'b0;
  int           n_checks = 0;
  int           n_pass = 0;

  fetch_instr_queue #(.DEPTH(DEPTH)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .fetch_valid_i   (fetch_valid_i),
    .fetch_accept_o  (fetch_accept_o),
    .fetch_pc_i      (fetch_pc_i),
    .fetch_instr_i   (fetch_instr_i),
    .fetch0_valid_o  (fetch0_valid_o),
    .fetch0_instr_o  (fetch0_instr_o),
    .fetch0_pc_o     (fetch0_pc_o),
    .fetch1_valid_o  (fetch1_valid_o),
    .fetch1_instr_o  (fetch1_instr_o),
    .fetch1_pc_o     (fetch1_pc_o),
    .issue0_accept_i (issue0_accept_i),
    .issue1_accept_i (issue1_accept_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Model: a plain queue of instructions; occupancy is its size.
  task automatic model_update();
    int  n;
    bit  acc;
    logic [31:0] base;
    if (flush_i) begin
      mq.delete();
    end else begin
      acc = (mq.size() <= DEPTH - 2);
      n = issue0_accept_i ? (issue1_accept_i ? 2 : 1) : 0;
      if (n > mq.size()) n = mq.size();
      repeat (n) void'(mq.pop_front());
      if (fetch_valid_i && acc) begin
        base = fetch_pc_i & 32'hFFFF_FFF8;
        if (fetch_pc_i[2]) begin
          mq.push_back('{instr: fetch_instr_i[63:32], pc: base + 32'd4});
        end else begin
          mq.push_back('{instr: fetch_instr_i[31:0],  pc: base});
          mq.push_back('{instr: fetch_instr_i[63:32], pc: base + 32'd4});
        end
      end
    end
  endtask

  always @(negedge clk_i) begin
    if (cmp_en && !rst_i) begin
      check("accept", {31'd0, fetch_accept_o}, {31'd0, mq.size() <= DEPTH - 2});
      check("slot0_valid", {31'd0, fetch0_valid_o}, {31'd0, mq.size() >= 1});
      check("slot1_valid", {31'd0, fetch1_valid_o}, {31'd0, mq.size() >= 2});
      if (mq.size() >= 1) begin
        check("slot0_instr", fetch0_instr_o, mq[0].instr);
        check("slot0_pc", fetch0_pc_o, mq[0].pc);
      end
      if (mq.size() >= 2) begin
        check("slot1_instr", fetch1_instr_o, mq[1].instr);
        check("slot1_pc", fetch1_pc_o, mq[1].pc);
      end
    end
  end

  // One clock: drive inputs, let the edge happen, advance the model, settle.
  task automatic cycle(input logic fv, input logic [31:0] pc, input logic [63:0] ins,
                       input logic i0, input logic i1, input logic fl);
    fetch_valid_i   = fv;
    fetch_pc_i      = pc;
    fetch_instr_i   = ins;
    issue0_accept_i = i0;
    issue1_accept_i = i1;
    flush_i         = fl;
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic pkt(input logic [31:0] pc);
    cycle(1'b1, pc, {pc + 32'h4400_0004, pc + 32'h4400_0000}, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic i0, input logic i1);
    cycle(1'b0, 32'd0, 64'd0, i0, i1, 1'b0);
  endtask

  task automatic do_flush();
    cycle(1'b0, 32'd0, 64'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    // Reset state.
    #3;
    check("rst_slot0_valid", {31'd0, fetch0_valid_o}, 32'd0);
    check("rst_slot1_valid", {31'd0, fetch1_valid_o}, 32'd0);
    check("rst_accept", {31'd0, fetch_accept_o}, 32'd1);
    check("rst_slot0_instr", fetch0_instr_o, 32'd0);
    check("rst_slot1_pc", fetch1_pc_o, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    cmp_en = 1'b1;

    // First packet, no issue.
    cycle(1'b1, 32'h1000, 64'h00000013_00100093, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    check("p1_slot0_instr", fetch0_instr_o, 32'h00100093);
    check("p1_slot0_pc", fetch0_pc_o, 32'h1000);
    check("p1_slot1_instr", fetch1_instr_o, 32'h00000013);
    check("p1_slot1_pc", fetch1_pc_o, 32'h1004);
    check("p1_slot1_valid", {31'd0, fetch1_valid_o}, 32'd1);
    check("p1_accept", {31'd0, fetch_accept_o}, 32'd1);

    // Redirect packet into an empty queue.
    do_flush();
    check("fl_slot0_valid", {31'd0, fetch0_valid_o}, 32'd0);
    cycle(1'b1, 32'h2004, 64'hCAFE0001_DEAD0002, 1'b0, 1'b0, 1'b0);
    check("rd_slot0_valid", {31'd0, fetch0_valid_o}, 32'd1);
    check("rd_slot0_pc", fetch0_pc_o, 32'h2004);
    check("rd_slot0_instr", fetch0_instr_o, 32'hCAFE0001);
    check("rd_slot1_valid", {31'd0, fetch1_valid_o}, 32'd0);

    // Fill to 8, hold a 5th packet, drain in order.
    do_flush();
    for (int k = 0; k < 4; k++) pkt(32'h3000 + 32'(8 * k));
    check("full_accept", {31'd0, fetch_accept_o}, 32'd0);
    pkt(32'h3020);
    check("held_slot0_pc", fetch0_pc_o, 32'h3000);
    for (int k = 1; k < 4; k++) begin
      idle(1'b1, 1'b1);
      check("drain_slot0_pc", fetch0_pc_o, 32'h3000 + 32'(8 * k));
      check("drain_slot1_pc", fetch1_pc_o, 32'h3004 + 32'(8 * k));
    end
    idle(1'b1, 1'b1);
    check("drained_empty", {31'd0, fetch0_valid_o}, 32'd0);

    // Occupancy 7 also blocks a packet.
    do_flush();
    pkt(32'h4004);
    for (int k = 1; k < 4; k++) pkt(32'h4000 + 32'(8 * k));
    check("seven_accept", {31'd0, fetch_accept_o}, 32'd0);

    // Dual issue with one packet per cycle: steady occupancy, wrapping pointers.
    do_flush();
    pkt(32'h7000);
    pkt(32'h7008);
    for (int k = 0; k < 12; k++) begin
      cycle(1'b1, 32'h7010 + 32'(8 * k), {32'h7014 + 32'(8 * k), 32'h7010 + 32'(8 * k)},
            1'b1, 1'b1, 1'b0);
      check("dual_slot0_pc", fetch0_pc_o, 32'h7008 + 32'(8 * k));
      check("dual_slot1_pc", fetch1_pc_o, 32'h700C + 32'(8 * k));
      check("dual_accept", {31'd0, fetch_accept_o}, 32'd1);
    end

    // Single issue, then an ignored issue1-only accept.
    do_flush();
    pkt(32'h8000);
    pkt(32'h8008);
    idle(1'b1, 1'b0);
    check("single1_pc", fetch0_pc_o, 32'h8004);
    idle(1'b1, 1'b0);
    check("single2_pc", fetch0_pc_o, 32'h8008);
    idle(1'b0, 1'b1);
    check("i1only_pc", fetch0_pc_o, 32'h8008);
    check("i1only_slot1_pc", fetch1_pc_o, 32'h800C);

    // Flush at occupancy 5 with a packet offered in the same cycle.
    do_flush();
    pkt(32'h5004);
    pkt(32'h5008);
    pkt(32'h5010);
    cycle(1'b1, 32'h6000, 64'h11111111_22222222, 1'b0, 1'b0, 1'b1);
    check("flush5_slot0_valid", {31'd0, fetch0_valid_o}, 32'd0);
    check("flush5_slot1_valid", {31'd0, fetch1_valid_o}, 32'd0);
    check("flush5_accept", {31'd0, fetch_accept_o}, 32'd1);
    idle(1'b0, 1'b0);
    check("flush5_absent", {31'd0, fetch0_valid_o}, 32'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, {$urandom, $urandom},
            1'($urandom), 1'($urandom), $urandom_range(0, 31) == 0);
    end

    // Asynchronous reset mid-stream.
    idle(1'b0, 1'b0);
    pkt(32'h9000);
    pkt(32'h9008);
    #2;
    cmp_en = 1'b0;
    rst_i  = 1'b1;
    mq.delete();
    #1;
    check("arst_slot0_valid", {31'd0, fetch0_valid_o}, 32'd0);
    check("arst_slot1_valid", {31'd0, fetch1_valid_o}, 32'd0);
    check("arst_accept", {31'd0, fetch_accept_o}, 32'd1);
    check("arst_slot0_pc", fetch0_pc_o, 32'd0);
    fetch_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    cmp_en = 1'b1;
    pkt(32'hA000);
    check("post_rst_pc", fetch0_pc_o, 32'hA000);
    idle(1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
